// File: rtl/register_shift_param_if.sv
// Bus bundle for register_shift_param: parallel/serial data,
// transfer control and status, with driver and register sides.
interface register_shift_param_if #(
    parameter int reg_width = 8,
    parameter int cnt_width = $clog2(reg_width + 1)
);
    logic [reg_width-1:0] reg_in;
    logic                 load;
    logic                 start;
    logic                 shift_en;
    logic                 ser_in;
    logic                 ser_out;
    logic [reg_width-1:0] reg_out;
    logic                 busy;
    logic                 done;
    logic [cnt_width-1:0] bit_cnt;

    modport master (
        output reg_in, load, start, shift_en, ser_in,
        input  ser_out, reg_out, busy, done, bit_cnt
    );

    modport slave (
        input  reg_in, load, start, shift_en, ser_in,
        output ser_out, reg_out, busy, done, bit_cnt
    );
endinterface

// File: rtl/register_shift_param.sv
// Parametrised shift register with parallel load/readback, serial
// in/out in either bit order, and a counted transfer with busy/done.
module register_shift_param #(
    parameter int                   reg_width   = 8,
    parameter logic [reg_width-1:0] reset_value = '0,
    parameter bit                   msb_first   = 1'b1,
    parameter int                   cnt_width   = $clog2(reg_width + 1)
) (
    input logic                   clk,
    input logic                   clear,
    register_shift_param_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [cnt_width-1:0] LAST_CNT =
        cnt_width'(reg_width - 1);

    state_t               state_q, state_d;
    logic [reg_width-1:0] reg_q, reg_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [reg_width-1:0] shifted;

    always_comb begin
        if (msb_first) begin
            shifted = {reg_q[reg_width-2:0], bus.ser_in};
        end else begin
            shifted = {bus.ser_in, reg_q[reg_width-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    reg_d   = bus.reg_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else if (bus.load) begin
                    reg_d = bus.reg_in;
                end
            end
            SHIFT: begin
                // restart outranks a coincident strobe
                if (bus.start) begin
                    reg_d = bus.reg_in;
                    cnt_d = '0;
                end else if (bus.shift_en) begin
                    reg_d = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            reg_q   <= reset_value;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.reg_out = reg_q;
    assign bus.bit_cnt = cnt_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.ser_out = msb_first ? reg_q[reg_width-1] : reg_q[0];

endmodule

// File: tb/tb_register_shift_param.sv
// Directed bench: one MSB-first and one LSB-first instance,
// checked with immediate assertions against hand-computed values.
module tb_register_shift_param;

    logic clk;
    logic clear;
    int   total;
    int   bad;

    register_shift_param_if #(.reg_width(8)) m_if ();
    register_shift_param_if #(.reg_width(8)) l_if ();

    register_shift_param #(
        .reg_width  (8),
        .reset_value(8'h5A),
        .msb_first  (1'b1)
    ) u_msb (
        .clk  (clk),
        .clear(clear),
        .bus  (m_if.slave)
    );

    register_shift_param #(
        .reg_width  (8),
        .reset_value(8'h5A),
        .msb_first  (1'b0)
    ) u_lsb (
        .clk  (clk),
        .clear(clear),
        .bus  (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sin_pat;
    logic [7:0] a5_pat;
    logic [7:0] lsb_pat;
    int         dones;

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b1;
        m_if.reg_in = '0; m_if.load = 0; m_if.start = 0;
        m_if.shift_en = 0; m_if.ser_in = 0;
        l_if.reg_in = '0; l_if.load = 0; l_if.start = 0;
        l_if.shift_en = 0; l_if.ser_in = 0;
        tick();

        chk("rst_reg_m", m_if.reg_out, 8'h5A);
        chk("rst_busy_m", m_if.busy, 0);
        chk("rst_done_m", m_if.done, 0);
        chk("rst_cnt_m", m_if.bit_cnt, 0);
        chk("rst_ser_m", m_if.ser_out, 0);
        chk("rst_reg_l", l_if.reg_out, 8'h5A);
        chk("rst_ser_l", l_if.ser_out, 0);

        // clear outranks load
        m_if.load = 1; m_if.reg_in = 8'hFF;
        tick();
        chk("clr_load_reg", m_if.reg_out, 8'h5A);
        clear = 0; m_if.load = 0;

        // MSB-first transfer
        m_if.reg_in = 8'hA5; m_if.start = 1;
        tick();
        m_if.start = 0;
        chk("msb_start_busy", m_if.busy, 1);
        chk("msb_start_reg", m_if.reg_out, 8'hA5);
        chk("msb_start_cnt", m_if.bit_cnt, 0);
        sin_pat = 8'b0011_1100;
        a5_pat  = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("msb_ser%0d", i), m_if.ser_out, a5_pat[7-i]);
            m_if.ser_in = sin_pat[7-i]; m_if.shift_en = 1;
            tick();
            chk($sformatf("msb_cnt%0d", i), m_if.bit_cnt, i + 1);
            chk($sformatf("msb_done%0d", i), m_if.done, i == 7);
            chk($sformatf("msb_busy%0d", i), m_if.busy, i != 7);
        end
        m_if.shift_en = 0; m_if.ser_in = 0;
        chk("msb_final_reg", m_if.reg_out, 8'h3C);
        tick();
        chk("msb_done_drop", m_if.done, 0);
        chk("msb_cnt_hold", m_if.bit_cnt, 8);

        // idle gating
        m_if.shift_en = 1; m_if.ser_in = 1;
        tick();
        m_if.shift_en = 0; m_if.ser_in = 0;
        chk("idle_shift_reg", m_if.reg_out, 8'h3C);
        chk("idle_shift_cnt", m_if.bit_cnt, 8);
        m_if.load = 1; m_if.reg_in = 8'h77;
        tick();
        m_if.load = 0;
        chk("idle_load_reg", m_if.reg_out, 8'h77);
        chk("idle_load_cnt", m_if.bit_cnt, 8);
        chk("idle_load_done", m_if.done, 0);

        // load ignored while busy
        m_if.start = 1; m_if.reg_in = 8'hA5;
        tick();
        m_if.start = 0;
        m_if.load = 1; m_if.reg_in = 8'h11;
        tick();
        m_if.load = 0;
        chk("busy_load_reg", m_if.reg_out, 8'hA5);
        chk("busy_load_busy", m_if.busy, 1);

        // restart after 3 shifts, with a coincident strobe
        m_if.ser_in = 0; m_if.shift_en = 1;
        repeat (3) tick();
        chk("rs_pre_reg", m_if.reg_out, 8'h28);
        chk("rs_pre_cnt", m_if.bit_cnt, 3);
        m_if.start = 1; m_if.reg_in = 8'hC3;
        tick();
        m_if.start = 0; m_if.shift_en = 0;
        chk("rs_reg", m_if.reg_out, 8'hC3);
        chk("rs_cnt", m_if.bit_cnt, 0);
        chk("rs_busy", m_if.busy, 1);
        chk("rs_done", m_if.done, 0);
        m_if.ser_in = 1; m_if.shift_en = 1;
        repeat (7) tick();
        chk("rs_done7", m_if.done, 0);
        tick();
        m_if.shift_en = 0; m_if.ser_in = 0;
        chk("rs_done8", m_if.done, 1);
        chk("rs_final_reg", m_if.reg_out, 8'hFF);
        chk("rs_final_busy", m_if.busy, 0);

        // start and load together act as start
        m_if.start = 1; m_if.load = 1; m_if.reg_in = 8'h3C;
        tick();
        m_if.start = 0; m_if.load = 0;
        chk("sl_busy", m_if.busy, 1);
        chk("sl_cnt", m_if.bit_cnt, 0);

        // abort after 5 shifts
        m_if.shift_en = 1;
        repeat (5) tick();
        m_if.shift_en = 0;
        chk("ab_cnt", m_if.bit_cnt, 5);
        clear = 1;
        tick();
        clear = 0;
        chk("ab_busy", m_if.busy, 0);
        chk("ab_reg", m_if.reg_out, 8'h5A);
        chk("ab_cnt0", m_if.bit_cnt, 0);
        chk("ab_done", m_if.done, 0);
        tick();
        chk("ab_done2", m_if.done, 0);

        // LSB-first transfer with spaced strobes
        l_if.reg_in = 8'h0F; l_if.start = 1;
        tick();
        l_if.start = 0;
        lsb_pat = 8'h0F;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_ser%0d", i), l_if.ser_out, lsb_pat[i]);
            l_if.ser_in = 1; l_if.shift_en = 1;
            tick();
            l_if.shift_en = 0; l_if.ser_in = 0;
            if (l_if.done) dones++;
            chk($sformatf("lsb_cnt%0d", i), l_if.bit_cnt, i + 1);
            repeat (2) begin
                tick();
                if (l_if.done) dones++;
                chk($sformatf("lsb_gap_cnt%0d", i), l_if.bit_cnt, i + 1);
            end
        end
        chk("lsb_final_reg", l_if.reg_out, 8'hFF);
        chk("lsb_busy", l_if.busy, 0);
        chk("lsb_done_count", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
